// File: rtl/guess_game_pkg.sv
// guess_game_pkg: shared states, LED patterns and seven-segment lookup for the guessing game
package guess_game_pkg;
   typedef enum logic [1:0] {IDLE, PLAY, WIN, LOSE} state_t;
   localparam logic [9:0] LED_HIGH = 10'b1111100000;
   localparam logic [9:0] LED_LOW  = 10'b0000011111;
   localparam logic [9:0] LED_WIN  = 10'h3FF;
   localparam logic [9:0] LED_LOSE = 10'b0101010101;
   localparam logic [7:0] SEG_BLANK = 8'hFF;
   // index 0 sits in the LSBs; all entries keep dp (bit 7) high
   localparam logic [9:0][7:0] SEG_LUT = {8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
                                          8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: one BCD digit to active-low {dp,g..a}; non-decimal codes blank the digit
module seg7_decode
   import guess_game_pkg::*;
(
   input  logic [3:0] bcd_i,
   input  logic       dp_on_i,
   output logic [7:0] seg_o
);
   always_comb seg_o = (bcd_i > 4'd9) ? SEG_BLANK : {~dp_on_i, SEG_LUT[bcd_i][6:0]};
endmodule

// File: rtl/guess_game_core.sv
// guess_game_core: multi-digit number guessing game with try limit, button front end
// and seven-segment/LED feedback
module guess_game_core
   import guess_game_pkg::*;
#(
   parameter int DIGITS    = 3,
   parameter int MAX_TRIES = 7,
   parameter int TW        = $clog2(MAX_TRIES + 1)
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              btn_inc,
   input  logic              btn_sel,
   input  logic              btn_submit,
   input  logic              secret_ld,
   input  logic [4*DIGITS-1:0] secret_bcd,
   output logic [8*DIGITS-1:0] seg,
   output logic [9:0]        led,
   output logic [TW-1:0]     tries_left,
   output logic              won,
   output logic              lost
);
   localparam int NB = 4 * DIGITS;
   localparam logic [1:0] LAST = 2'(DIGITS - 1);
   logic [2:0] sync1_q, sync2_q, prev_q, btn_edge;
   logic [NB-1:0] cnt_q, cnt_d, guess_q, secret_q;
   logic [1:0] cursor_q;
   logic [TW-1:0] tries_q;
   logic [9:0] led_q;
   logic [3:0] cur_dig;
   logic carry, restart, last_try;
   state_t state_q;

   // bit 2 = submit, 1 = inc, 0 = sel; index order is also the priority order
   assign btn_edge = sync2_q & ~prev_q;
   assign cur_dig  = guess_q[{cursor_q, 2'b00} +: 4];
   assign restart  = (state_q == IDLE) || ((state_q == WIN || state_q == LOSE) && btn_edge[2]);
   assign last_try = tries_q <= TW'(1);

   always_comb begin
      cnt_d = cnt_q;
      carry = 1'b1;
      for (int i = 0; i < DIGITS; i++)
         if (carry) begin
            carry = cnt_q[4*i +: 4] == 4'd9;
            cnt_d[4*i +: 4] = carry ? 4'd0 : cnt_q[4*i +: 4] + 4'd1;
         end
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= {btn_submit, btn_inc, btn_sel};
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         cnt_q   <= cnt_d;
      end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q  <= IDLE;
         guess_q  <= '0;
         cursor_q <= LAST;
         tries_q  <= TW'(MAX_TRIES);
         led_q    <= '0;
         secret_q <= '0;
      end else begin
         if (!enable) begin
            state_q  <= IDLE;
            guess_q  <= '0;
            cursor_q <= LAST;
            tries_q  <= TW'(MAX_TRIES);
            led_q    <= '0;
         end else if (restart) begin
            state_q  <= PLAY;
            secret_q <= cnt_q;
            guess_q  <= '0;
            cursor_q <= LAST;
            tries_q  <= TW'(MAX_TRIES);
            led_q    <= '0;
         end else if (state_q == PLAY) begin
            if (btn_edge[2]) begin
               if (guess_q == secret_q) begin
                  state_q <= WIN;
                  led_q   <= LED_WIN;
               end else begin
                  tries_q <= tries_q - TW'(tries_q != '0);
                  state_q <= last_try ? LOSE : PLAY;
                  led_q   <= last_try ? LED_LOSE : (guess_q > secret_q ? LED_HIGH : LED_LOW);
               end
            end else if (btn_edge[1]) begin
               guess_q[{cursor_q, 2'b00} +: 4] <= (cur_dig == 4'd9) ? 4'd0 : cur_dig + 4'd1;
               led_q <= '0;
            end else if (btn_edge[0])
               cursor_q <= (cursor_q == LAST) ? 2'd0 : cursor_q + 2'd1;
         end
         // test load overrides a same-cycle capture
         if (enable && secret_ld) secret_q <= secret_bcd;
      end

   for (genvar g = 0; g < DIGITS; g++) begin : g_dig
      logic [3:0] bcd;
      assign bcd = (state_q == IDLE) ? 4'hF :
                   (state_q == LOSE) ? secret_q[4*g +: 4] : guess_q[4*g +: 4];
      seg7_decode u_dec (
         .bcd_i   (bcd),
         .dp_on_i (state_q == PLAY && cursor_q == 2'(g)),
         .seg_o   (seg[8*g +: 8])
      );
   end

   assign led        = led_q;
   assign tries_left = tries_q;
   assign won        = state_q == WIN;
   assign lost       = state_q == LOSE;
endmodule

// File: tb/tb_guess_game_core.sv
// tb_guess_game_core: directed game sessions with hand-computed display, LED and try values
module tb_guess_game_core;
   logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
   logic btn_inc = 1'b0, btn_sel = 1'b0, btn_submit = 1'b0, secret_ld = 1'b0;
   logic [11:0] secret_bcd = '0;
   logic [23:0] seg;
   logic [9:0] led;
   logic [2:0] tries_left;
   logic won, lost;
   int checks = 0, errors = 0;

   guess_game_core #(.DIGITS(3), .MAX_TRIES(7)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .btn_inc(btn_inc), .btn_sel(btn_sel),
      .btn_submit(btn_submit), .secret_ld(secret_ld), .secret_bcd(secret_bcd),
      .seg(seg), .led(led), .tries_left(tries_left), .won(won), .lost(lost)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // m = {submit, inc, sel}; one-cycle pulse, returns once the action is visible
   task automatic press(input logic [2:0] m);
      {btn_submit, btn_inc, btn_sel} = m;
      @(negedge clk);
      {btn_submit, btn_inc, btn_sel} = 3'b000;
      repeat (2) @(negedge clk);
   endtask

   task automatic load(input logic [11:0] s);
      secret_ld = 1'b1;
      secret_bcd = s;
      @(negedge clk);
      secret_ld = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_seg", seg, 24'hFFFFFF);
      check("rst_led", led, 10'h000);
      check("rst_tries", tries_left, 3'd7);
      check("rst_flags", {won, lost}, 2'b00);
      rst_n = 1'b1;
      @(negedge clk);
      enable = 1'b1;
      load(12'h123);
      check("play_seg", seg, 24'h40C0C0);
      press(3'b100);
      check("low_led", led, 10'h01F);
      check("low_tries", tries_left, 3'd6);
      check("low_seg", seg, 24'h40C0C0);
      press(3'b001);
      check("wrap_c0", seg, 24'hC0C040);
      repeat (3) press(3'b010);
      check("d0_3", seg, 24'hC0C030);
      check("inc_led_clr", led, 10'h000);
      press(3'b001);
      check("cur1", seg, 24'hC040B0);
      repeat (2) press(3'b010);
      check("d1_2", seg, 24'hC024B0);
      press(3'b001);
      check("cur2", seg, 24'h40A4B0);
      press(3'b010);
      check("d2_1", seg, 24'h79A4B0);
      press(3'b100);
      check("win_led", led, 10'h3FF);
      check("win_flag", {won, lost}, 2'b10);
      check("win_seg", seg, 24'hF9A4B0);
      press(3'b010);
      check("win_inc_ign", seg, 24'hF9A4B0);
      press(3'b100);
      check("restart_seg", seg, 24'h40C0C0);
      check("restart_tries", tries_left, 3'd7);
      check("restart_flags", {won, lost, led}, 12'h000);
      load(12'h005);
      press(3'b001);
      repeat (9) press(3'b010);
      check("d0_9", seg, 24'hC0C010);
      press(3'b100);
      check("high_led", led, 10'h3E0);
      check("high_tries", tries_left, 3'd6);
      press(3'b010);
      check("d0_wrap", seg, 24'hC0C040);
      check("wrap_led_clr", led, 10'h000);
      press(3'b110);
      check("prio_led", led, 10'h01F);
      check("prio_tries", tries_left, 3'd5);
      check("prio_seg", seg, 24'hC0C040);
      btn_inc = 1'b1;
      repeat (20) @(negedge clk);
      btn_inc = 1'b0;
      repeat (3) @(negedge clk);
      check("hold_once", seg, 24'hC0C079);
      enable = 1'b0;
      @(negedge clk);
      check("dis_seg", seg, 24'hFFFFFF);
      check("dis_tries", tries_left, 3'd7);
      check("dis_led", led, 10'h000);
      enable = 1'b1;
      load(12'h999);
      check("reen_seg", seg, 24'h40C0C0);
      repeat (6) press(3'b100);
      check("six_tries", tries_left, 3'd1);
      check("six_state", {lost, led}, 11'h01F);
      press(3'b100);
      check("lose_flags", {won, lost}, 2'b01);
      check("lose_led", led, 10'h155);
      check("lose_tries", tries_left, 3'd0);
      check("lose_seg", seg, 24'h909090);
      press(3'b010);
      check("lose_inc_ign", seg, 24'h909090);
      press(3'b100);
      check("lrestart_tries", tries_left, 3'd7);
      check("lrestart_flags", {won, lost}, 2'b00);
      check("lrestart_seg", seg, 24'h40C0C0);
      load(12'h500);
      press(3'b010);
      check("d2_inc", seg, 24'h79C0C0);
      press(3'b100);
      check("pre_rst_led", led, 10'h01F);
      #2 rst_n = 1'b0;
      #1;
      check("arst_seg", seg, 24'hFFFFFF);
      check("arst_led", led, 10'h000);
      check("arst_tries", tries_left, 3'd7);
      check("arst_flags", {won, lost}, 2'b00);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
